// File: rtl/trig_buf_pkg.sv
// rtl/trig_buf_pkg.sv - shared defaults, FSM encoding and clog2 helper for the trigger buffer manager
package trig_buf_pkg;

    localparam int DEF_NUM_SRC   = 4;
    localparam int DEF_NUM_BUF   = 4;
    localparam int DEF_HOLDOFF_W = 8;
    localparam int DEF_LOST_W    = 16;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_HOLDOFF = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/trig_edge_prescaler.sv
// rtl/trig_edge_prescaler.sv - per-source rising-edge detect and mask, optional prescale under TRIG_BUF_PRESCALE_EN
module trig_edge_prescaler
    import trig_buf_pkg::*;
(
    input  logic       clk250_i,
    input  logic       rst_n_i,
    input  logic       trig_i,
    input  logic       mask_i,
`ifdef TRIG_BUF_PRESCALE_EN
    input  logic [7:0] prescale_i,
`endif
    output logic       edge_o
);

    logic trig_q;
    logic qual_edge;

    // Previous trigger level, used for rising-edge detection.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) trig_q <= 1'b0;
        else          trig_q <= trig_i;
    end

    assign qual_edge = trig_i & ~trig_q & mask_i;

`ifdef TRIG_BUF_PRESCALE_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       pass;

    // Swallow prescale_i qualified edges, pass the next one; masking restarts the count.
    always_comb begin
        pass  = 1'b0;
        cnt_d = cnt_q;
        if (!mask_i) begin
            cnt_d = '0;
        end else if (qual_edge) begin
            if (cnt_q == prescale_i) begin
                pass  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Prescale edge counter.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign edge_o = pass;
`else
    assign edge_o = qual_edge;
`endif

endmodule

// File: rtl/trig_buffer_manager.sv
// rtl/trig_buffer_manager.sv - in-order trigger buffer allocator with holdoff and lost counting; TRIG_BUF_PRESCALE_EN adds prescale_i
module trig_buffer_manager
    import trig_buf_pkg::*;
#(
    parameter  int NUM_SRC   = DEF_NUM_SRC,
    parameter  int NUM_BUF   = DEF_NUM_BUF,
    parameter  int HOLDOFF_W = DEF_HOLDOFF_W,
    parameter  int LOST_W    = DEF_LOST_W,
    localparam int BUF_W     = clog2(NUM_BUF)
) (
    input  logic                 clk250_i,
    input  logic                 rst_n_i,
    input  logic [NUM_SRC-1:0]   trig_i,
    input  logic [NUM_SRC-1:0]   src_mask_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    input  logic                 clear_i,
    input  logic [BUF_W-1:0]     clear_buffer_i,
`ifdef TRIG_BUF_PRESCALE_EN
    input  logic [NUM_SRC*8-1:0] prescale_i,
`endif
    output logic                 digitize_o,
    output logic [BUF_W-1:0]     digitize_buffer_o,
    output logic [NUM_SRC-1:0]   digitize_source_o,
    output logic [NUM_BUF-1:0]   hold_o,
    output logic [BUF_W:0]       occupancy_o,
    output logic                 dead_o,
    output logic [LOST_W-1:0]    lost_count_o,
    output logic                 clear_err_o
);

    localparam logic [BUF_W:0] OCC_FULL = (BUF_W+1)'(NUM_BUF);

    logic [NUM_SRC-1:0]   src_edge;
    logic                 any_edge;
    logic                 accept;
    logic                 clr_ok;
    logic [0:0]           state_q, state_d;
    logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
    logic [BUF_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [BUF_W:0]       occ_q, occ_d;
    logic [NUM_BUF-1:0]   hold_q, hold_d;
    logic                 dig_q;
    logic [BUF_W-1:0]     dig_buf_q;
    logic [NUM_SRC-1:0]   dig_src_q;
    logic                 dead_q;
    logic [LOST_W-1:0]    lost_q;
    logic                 clr_err_q;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        trig_edge_prescaler u_edge (
            .clk250_i   (clk250_i),
            .rst_n_i    (rst_n_i),
            .trig_i     (trig_i[s]),
            .mask_i     (src_mask_i[s]),
`ifdef TRIG_BUF_PRESCALE_EN
            .prescale_i (prescale_i[8*s +: 8]),
`endif
            .edge_o     (src_edge[s])
        );
    end

    assign any_edge = |src_edge;
    assign accept   = any_edge && (state_q == ST_IDLE) && (occ_q < OCC_FULL);
    assign clr_ok   = clear_i && (occ_q != '0) && (clear_buffer_i == rd_ptr_q);

    // Holdoff FSM: an accept with nonzero holdoff blocks exactly holdoff_i cycles.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (holdoff_i != '0)) begin
                    state_d = ST_HOLDOFF;
                    hcnt_d  = holdoff_i;
                end
            end
            default: begin
                if (hcnt_q == HOLDOFF_W'(1)) state_d = ST_IDLE;
                hcnt_d = hcnt_q - HOLDOFF_W'(1);
            end
        endcase
    end

    // Next occupancy and hold bits; a simultaneous accept and clear touch different buffers.
    always_comb begin
        occ_d  = occ_q;
        hold_d = hold_q;
        if (accept && !clr_ok)      occ_d = occ_q + (BUF_W+1)'(1);
        else if (clr_ok && !accept) occ_d = occ_q - (BUF_W+1)'(1);
        if (clr_ok) hold_d[rd_ptr_q] = 1'b0;
        if (accept) hold_d[wr_ptr_q] = 1'b1;
    end

    // FSM and holdoff counter registers.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Buffer ring: write/read pointers, occupancy and HOLD bits.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            hold_q   <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + BUF_W'(1);
            if (clr_ok) rd_ptr_q <= rd_ptr_q + BUF_W'(1);
            occ_q  <= occ_d;
            hold_q <= hold_d;
        end
    end

    // Digitize command, dead flag, lost counter and sticky clear error.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dig_q     <= 1'b0;
            dig_buf_q <= '0;
            dig_src_q <= '0;
            dead_q    <= 1'b0;
            lost_q    <= '0;
            clr_err_q <= 1'b0;
        end else begin
            dig_q <= accept;
            if (accept) begin
                dig_buf_q <= wr_ptr_q;
                dig_src_q <= src_edge;
            end
            dead_q <= (occ_d == OCC_FULL) || (state_d == ST_HOLDOFF);
            if (any_edge && !accept && (lost_q != '1)) lost_q <= lost_q + LOST_W'(1);
            if (clear_i && !clr_ok) clr_err_q <= 1'b1;
        end
    end

    assign digitize_o        = dig_q;
    assign digitize_buffer_o = dig_buf_q;
    assign digitize_source_o = dig_src_q;
    assign hold_o            = hold_q;
    assign occupancy_o       = occ_q;
    assign dead_o            = dead_q;
    assign lost_count_o      = lost_q;
    assign clear_err_o       = clr_err_q;

endmodule

// File: doc/trig_buffer_manager.md
Name: trig_buffer_manager

Overview:
Parametrised next-generation trigger buffer manager for the TURF trigger path, running entirely in the 250 MHz domain.
- Arbitrates NUM_SRC trigger sources (RF, PPS1, PPS2, soft, expandable) with per-source masking.
- Allocates NUM_BUF digitizer buffers strictly in order, drives per-buffer HOLD and emits a digitize command to the event generator.
- Enforces a programmable post-trigger holdoff and counts lost triggers.
- Frees buffers in order on readout clear.

Parameters:
NUM_SRC, 4, number of trigger sources.
NUM_BUF, 4, number of digitizer buffers; must be a power of 2, minimum 2.
HOLDOFF_W, 8, width of the holdoff cycle count input.
LOST_W, 16, width of the saturating lost-trigger counter.

Ports:
clk250_i  in  1  250 MHz clock; all logic is in this domain.
rst_n_i  in  1  asynchronous, active-low reset.
trig_i  in  NUM_SRC  level trigger inputs, already synchronous to clk250_i.
src_mask_i  in  NUM_SRC  1 = source enabled.
holdoff_i  in  HOLDOFF_W  cycles of holdoff after each accepted trigger.
clear_i  in  1  one-cycle pulse: readout of a buffer is finished.
clear_buffer_i  in  log2(NUM_BUF)  index of the buffer being cleared.
digitize_o  out  1  one-cycle digitize command.
digitize_buffer_o  out  log2(NUM_BUF)  buffer selected; held until the next accept.
digitize_source_o  out  NUM_SRC  qualified edges that caused the accept; held until the next accept.
hold_o  out  NUM_BUF  per-buffer HOLD.
occupancy_o  out  log2(NUM_BUF)+1  number of held buffers.
dead_o  out  1  high when full or in holdoff.
lost_count_o  out  LOST_W  saturating count of rejected triggers.
clear_err_o  out  1  sticky: out-of-order clear was seen.

Behaviour:
Reset values:
- All outputs reset to 0.
- wr_ptr, rd_ptr, holdoff counter and trig_q reset to 0.
- FSM resets to IDLE.

Edge qualification:
- trig_q <= trig_i every cycle.
- edge = trig_i & ~trig_q & src_mask_i.
- any_edge = |edge.

Accept rule:
- A trigger is accepted when any_edge is set, FSM = IDLE, and the registered occupancy_o < NUM_BUF.

Latency and outputs on accept:
- If trig_i first goes high in cycle N, then in cycle N+1:
  - digitize_o = 1.
  - digitize_buffer_o = wr_ptr.
  - digitize_source_o = edge (all simultaneous sources reported; there is no priority).
  - hold_o[wr_ptr] is set.
  - wr_ptr increments, wrapping modulo NUM_BUF.
  - occupancy increments.

FSM states:
- IDLE: on accept, if holdoff_i != 0, load the counter with holdoff_i and go to HOLDOFF; if holdoff_i == 0, stay in IDLE (back-to-back accepts are allowed).
- HOLDOFF: decrement the counter each cycle; return to IDLE when the counter reaches 1. The holdoff is exactly holdoff_i cycles, during which no accept is possible.

Lost triggers:
- Any cycle with any_edge set and no accept (holdoff or full) increments lost_count_o by 1, regardless of how many sources have edges.
- The counter saturates at all-ones.

Clear handling:
- clear_i with clear_buffer_i == rd_ptr: clear hold_o[rd_ptr], increment rd_ptr (wrapping), decrement occupancy.
- clear_i with clear_buffer_i != rd_ptr: ignored, clear_err_o set (sticky until reset).
- clear_i while occupancy is 0: ignored, clear_err_o set.

Simultaneous events:
- Accept and valid clear in the same cycle: occupancy unchanged; both hold bits update.
- Full is evaluated on the registered occupancy, so a trigger arriving in the same cycle as a clear while full is rejected and counted as lost.

Dead flag:
- dead_o is registered and equals (next occupancy == NUM_BUF) || (next state == HOLDOFF).
- It is high in the same cycle as the digitize_o that causes it.

Reset mid-operation:
- All holds drop immediately (asynchronous).
- Any pending holdoff is abandoned.

Optional Feature:
Macro TRIG_BUF_PRESCALE_EN.
- Defined:
  - Adds input prescale_i, width NUM_SRC*8.
  - Each source has an 8-bit counter of its qualified edges.
  - A source's edge passes only when its counter equals prescale_i[8s+:8]; the counter then resets to 0.
  - Prescale 0 passes every edge.
  - Counters reset to 0 when the source is masked.
  - Edges swallowed by the prescaler are not counted as lost.
- Undefined:
  - The prescale_i port and the counters are absent.
  - Qualified edges pass directly.

Decomposition:
Shared package trig_buf_pkg:
- clog2 function.
- FSM state encoding (IDLE, HOLDOFF).
- Default parameter constants.

Sub-module trig_edge_prescaler:
- Per-source edge detect, mask and optional prescale.
- Generate-instantiated NUM_SRC times.

Test Plan:
- Single accept: pulse trig_i[0], holdoff_i = 3 -> digitize_o one cycle later, digitize_buffer_o = 0, digitize_source_o = 0001, hold_o = 0001, dead_o high for 3 cycles.
- Simultaneous sources: trig_i[1] and trig_i[3] rise in the same cycle -> one accept, digitize_source_o = 1010, lost_count_o unchanged.
- Fill and wrap: 5 triggers with holdoff_i = 0 and no clears (NUM_BUF = 4) -> buffers 0,1,2,3 held, dead_o = 1, 5th trigger gives lost_count_o = 1; clear buffer 0 and retrigger -> buffer 0 is reused.
- Trigger inside holdoff: holdoff_i = 10, second edge 4 cycles after accept -> lost_count_o = 1, no second digitize_o.
- Out-of-order clear: clear_buffer_i = 2 while rd_ptr = 0 -> clear_err_o = 1, hold_o unchanged; full-plus-simultaneous clear and trigger -> trigger lost, occupancy drops to 3.
- Async reset during holdoff with 3 buffers held -> all outputs 0 without a clock edge; with TRIG_BUF_PRESCALE_EN defined and prescale 2, 6 edges -> exactly 2 digitize_o pulses.
